pipe_stage_skid_reg: RTL and testbench



---
 rtl/pipe_stage_skid_reg.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid_reg
//  Purpose  : Parametrised inter-stage pipeline register with a valid/ready
//             handshake and a 2-entry skid buffer. It also provides a
//             synchronous flush and drives a NOP bubble value whenever the
//             stage is empty. in_ready is decoded from registers only, so
//             downstream back-pressure never forms a combinational path
//             through the stage.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH        payload width in bits
//    NOP_VALUE    value on out_data whenever out_valid = 0
//    CNT_WIDTH    width of bubble_count (optional feature only)
//  Ports
//    clk          in   1          rising-edge clock
//    reset        in   1          asynchronous active-high reset
//    in_data      in   WIDTH      payload from upstream
//    in_valid     in   1          upstream beat present
//    in_ready     out  1          stage can accept a beat this cycle
//    out_data     out  WIDTH      payload downstream (NOP_VALUE when idle)
//    out_valid    out  1          stage holds a valid beat
//    out_ready    in   1          downstream accepts the beat this cycle
//    flush        in   1          synchronous kill of all held beats
//    bubble_count out  CNT_WIDTH  saturating bubble counter (optional)
//  Optional feature
//    `define PIPE_STAGE_BUBBLE_COUNT_EN adds the bubble_count port and its
//    counter. Without it the port and logic are absent.
// ============================================================================
module pipe_stage_skid_reg #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int unsigned      CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush
`ifdef PIPE_STAGE_BUBBLE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] bubble_count
`endif
);

  // State bit 0 is the main-entry valid and bit 1 is the skid-entry valid,
  // so the output decode reads the valids straight off the state register.
  localparam logic [1:0] c_ST_EMPTY = 2'b00;
  localparam logic [1:0] c_ST_FULL  = 2'b01;
  localparam logic [1:0] c_ST_SKID  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             w_accept;
  logic             w_drain;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;

  // State and data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_ST_EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and data-load decode
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A beat offered alongside flush is dropped even though in_ready=1;
      // a drain in the same cycle has already completed downstream.
      state_d = c_ST_EMPTY;
    end else begin
      case (state_q)
        c_ST_EMPTY: begin
          if (w_accept) begin
            state_d = c_ST_FULL;
            main_d  = in_data;
          end
        end
        c_ST_FULL: begin
          if (w_accept && w_drain) begin
            main_d = in_data;
          end else if (w_accept) begin
            // Downstream stalled: park the new beat behind the held one.
            state_d = c_ST_SKID;
            skid_d  = in_data;
          end else if (w_drain) begin
            state_d = c_ST_EMPTY;
          end
        end
        c_ST_SKID: begin
          if (w_drain) begin
            state_d = c_ST_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = c_ST_EMPTY;
        end
      endcase
    end
  end

  // Output decode, registers only
  always_comb begin
    in_ready  = (state_q != c_ST_SKID);
    out_valid = state_q[0];
    out_data  = state_q[0] ? main_q : NOP_VALUE;
  end

`ifdef PIPE_STAGE_BUBBLE_COUNT_EN
  logic [CNT_WIDTH-1:0] bubble_q;

  // Counts every idle edge, including flush-induced bubbles; sticks at max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_q <= '0;
    end else if (!out_valid && (bubble_q != '1)) begin
      bubble_q <= bubble_q + CNT_WIDTH'(1);
    end
  end

  assign bubble_count = bubble_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_skid_reg
//  Purpose  : Self-checking bench for pipe_stage_skid_reg. A vector table
//             covers streaming, back-pressure and flush; hand-written
//             sequences cover asynchronous reset and bubble counting. A
//             queue model tracks the beats held in the stage and is compared
//             every cycle.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_pipe_stage_skid_reg;

  localparam int              W   = 16;
  localparam logic [W-1:0]    NOP = '0;
  localparam int              CW  = 4;
  localparam int              NV  = 21;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         flush;
`ifdef PIPE_STAGE_BUBBLE_COUNT_EN
  logic [CW-1:0] bubble_count;
  int            cnt_exp;
`endif

  pipe_stage_skid_reg #(
    .WIDTH     (W),
    .NOP_VALUE (NOP),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .flush        (flush)
`ifdef PIPE_STAGE_BUBBLE_COUNT_EN
    ,
    .bubble_count (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Beats held by the stage, oldest first; pushed on accept, popped on drain.
  logic [W-1:0] sb_q[$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         f;
    logic         ov;
    logic [W-1:0] od;
    logic         ir;
  } vec_t;

  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus, compare the current outputs against the
  // model just before the edge, update the model, then step past the edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bit acc;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #4;
    chk("out_valid", out_valid, sb_q.size() != 0);
    chk("in_ready", in_ready, sb_q.size() < 2);
    if (sb_q.size() != 0) chk("out_data", out_data, sb_q[0]);
    else                  chk("out_data_nop", out_data, NOP);
`ifdef PIPE_STAGE_BUBBLE_COUNT_EN
    chk("bubble_count", bubble_count, cnt_exp);
    if (sb_q.size() == 0 && cnt_exp < (2**CW - 1)) cnt_exp++;
`endif
    acc = v && (sb_q.size() < 2);
    if (sb_q.size() != 0 && r) void'(sb_q.pop_front());
    if (acc && !f) sb_q.push_back(d);
    if (f) sb_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {in_valid, in_data, out_ready, flush, exp out_valid, exp out_data, exp in_ready}
    // Expected values are observed right after the edge that consumes the row.
    tbl[0]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 1'b1, 16'h1111, 1'b1};
    tbl[1]  = '{1'b1, 16'h2222, 1'b1, 1'b0, 1'b1, 16'h2222, 1'b1};
    tbl[2]  = '{1'b1, 16'h3333, 1'b1, 1'b0, 1'b1, 16'h3333, 1'b1};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[4]  = '{1'b1, 16'hA001, 1'b0, 1'b0, 1'b1, 16'hA001, 1'b1};
    tbl[5]  = '{1'b1, 16'hA002, 1'b0, 1'b0, 1'b1, 16'hA001, 1'b0};
    tbl[6]  = '{1'b1, 16'hA003, 1'b0, 1'b0, 1'b1, 16'hA001, 1'b0};
    tbl[7]  = '{1'b1, 16'hA003, 1'b0, 1'b0, 1'b1, 16'hA001, 1'b0};
    tbl[8]  = '{1'b1, 16'hA003, 1'b1, 1'b0, 1'b1, 16'hA002, 1'b1};
    tbl[9]  = '{1'b1, 16'hA003, 1'b1, 1'b0, 1'b1, 16'hA003, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[11] = '{1'b1, 16'hC001, 1'b0, 1'b0, 1'b1, 16'hC001, 1'b1};
    tbl[12] = '{1'b1, 16'hC002, 1'b0, 1'b0, 1'b1, 16'hC001, 1'b0};
    tbl[13] = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[14] = '{1'b1, 16'hD001, 1'b0, 1'b0, 1'b1, 16'hD001, 1'b1};
    tbl[15] = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[17] = '{1'b1, 16'hE001, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[18] = '{1'b1, 16'hE002, 1'b1, 1'b0, 1'b1, 16'hE002, 1'b1};
    tbl[19] = '{1'b1, 16'hE003, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[20] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
`ifdef PIPE_STAGE_BUBBLE_COUNT_EN
    cnt_exp   = 0;
`endif
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, NOP);
    chk("reset_in_ready", in_ready, 1'b1);
`ifdef PIPE_STAGE_BUBBLE_COUNT_EN
    chk("reset_bubble_count", bubble_count, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;

    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].ir);
    end

    // Random handshake traffic with occasional flushes against the model.
    repeat (300) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 24) == 0));
    end
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset while FULL: outputs must clear with no clock edge.
    cycle(1'b1, 16'h5A5A, 1'b0, 1'b0);
    chk("full_5a5a", out_data, 16'h5A5A);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_out_data", out_data, NOP);
    chk("async_rst_in_ready", in_ready, 1'b1);
    sb_q.delete();
`ifdef PIPE_STAGE_BUBBLE_COUNT_EN
    chk("async_rst_bubble_count", bubble_count, 0);
    cnt_exp = 0;
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 16'h0042, 1'b1, 1'b0);
    chk("post_rst_out_valid", out_valid, 1'b1);
    chk("post_rst_out_data", out_data, 16'h0042);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Long idle stretch: counter saturates at all-ones.
    repeat (20) cycle(1'b0, '0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_BUBBLE_COUNT_EN
    chk("bubble_saturated", bubble_count, 2**CW - 1);
`endif
    chk("idle_out_valid", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
